// File: rtl/mod12_load_scheduler_pkg.sv
// mod12_load_scheduler_pkg: shared FSM encoding and default sizing for the load scheduler
package mod12_load_scheduler_pkg;
    localparam int W_DEF   = 4;
    localparam int MOD_DEF = 12;
    typedef enum logic [1:0] {IDLE, ISSUE, VERIFY, DONE} state_e;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-input round-robin grant; last pointer favours requester 0 out of reset
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic       gnt_o
);
    logic last_q;
    assign gnt_o = &req_i ? ~last_q : req_i[1];
    always_ff @(posedge clk or negedge rst)
        if (!rst) last_q <= 1'b1;
        else if (en_i) last_q <= gnt_o;
endmodule

// File: rtl/mod12_load_scheduler.sv
// mod12_load_scheduler: arbitrates two requesters onto the counter load port and verifies each load
module mod12_load_scheduler
    import mod12_load_scheduler_pkg::*;
#(
    parameter int W   = W_DEF,
    parameter int MOD = MOD_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   req,
    input  logic [W-1:0] preset0,
    input  logic [W-1:0] preset1,
    input  logic [W-1:0] q,
    output logic         load,
    output logic [W-1:0] I,
    output logic [1:0]   ack,
    output logic [1:0]   err,
    output logic         busy,
    output logic         tc
);
    localparam logic [W-1:0] TOP = W'(MOD - 1);
    state_e       state_q;
    logic [W-1:0] pre_q, i_q, pre_d;
    logic         gnt_q, load_q, gnt;
    logic [1:0]   ack_q, err_q;
    assign pre_d = gnt ? preset1 : preset0;
    rr_arbiter2 u_arb (
        .clk  (clk),
        .rst  (rst),
        .req_i(req),
        .en_i (state_q == IDLE && |req),
        .gnt_o(gnt)
    );
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state_q <= IDLE;
            pre_q   <= '0;
            gnt_q   <= 1'b0;
            load_q  <= 1'b0;
            i_q     <= '0;
            ack_q   <= 2'b00;
            err_q   <= 2'b00;
        end else begin
            load_q <= 1'b0;
            ack_q  <= 2'b00;
            err_q  <= 2'b00;
            case (state_q)
                IDLE: if (|req) begin
                    pre_q <= pre_d;
                    gnt_q <= gnt;
                    if (pre_d <= TOP) begin
                        state_q <= ISSUE;
                        load_q  <= 1'b1;
                        i_q     <= pre_d;
                    end else begin
                        // out-of-range preset completes at once without touching the counter
                        state_q <= DONE;
                        ack_q   <= 2'b01 << gnt;
                        err_q   <= 2'b01 << gnt;
                    end
                end
                ISSUE: state_q <= VERIFY;
                VERIFY: begin
                    state_q <= DONE;
                    ack_q   <= 2'b01 << gnt_q;
                    err_q   <= (q != pre_q) ? 2'b01 << gnt_q : 2'b00;
                end
                default: state_q <= IDLE;
            endcase
        end
    assign load = load_q;
    assign I    = i_q;
    assign ack  = ack_q;
    assign err  = err_q;
    assign busy = state_q != IDLE;
    assign tc   = q == TOP;
endmodule

// File: tb/tb_mod12_load_scheduler.sv
// tb_mod12_load_scheduler: vector table, corner sequences and randomized run against a transaction-level model
module tb_mod12_load_scheduler;
    logic       clk = 1'b0, rst = 1'b0, stuck = 1'b0;
    logic [1:0] req = 2'b00;
    logic [3:0] p0 = '0, p1 = '0, qc;
    logic       load, busy, tc;
    logic [3:0] I;
    logic [1:0] ack, err;
    int         n_pass = 0, n_chk = 0;

    mod12_load_scheduler dut (
        .clk(clk), .rst(rst), .req(req), .preset0(p0), .preset1(p1), .q(qc),
        .load(load), .I(I), .ack(ack), .err(err), .busy(busy), .tc(tc)
    );

    always #5 clk = ~clk;

    // mod-12 counter environment; stuck models a counter that ignores load and sits at 0
    always_ff @(posedge clk or negedge rst)
        if (!rst) qc <= '0;
        else if (stuck) qc <= '0;
        else if (load) qc <= I;
        else qc <= (qc == 4'd11) ? 4'd0 : qc + 4'd1;

    typedef struct {
        logic [1:0] rq;
        logic [3:0] a, b;
        logic       st;
        logic [1:0] xack, xerr;
        int         lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; req = 2'b00; stuck = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_ack(output logic [1:0] a, output logic [1:0] e, output int lat,
                            output int nld, output logic [3:0] li);
        a = 2'b00; e = 2'b00; nld = 0; li = '0;
        for (lat = 1; lat <= 10; lat++) begin
            @(negedge clk);
            if (load) begin nld++; li = I; end
            if (ack != 2'b00) begin a = ack; e = err; return; end
        end
    endtask

    vec_t       vt[8];
    logic [1:0] ga, ge;
    int         lat, nld;
    logic [3:0] li;

    initial begin
        vt[0] = '{2'b01, 4'd6, 4'd0,  1'b0, 2'b01, 2'b00, 3};
        vt[1] = '{2'b10, 4'd0, 4'd13, 1'b0, 2'b10, 2'b10, 1};
        vt[2] = '{2'b01, 4'd5, 4'd0,  1'b1, 2'b01, 2'b01, 3};
        vt[3] = '{2'b10, 4'd0, 4'd11, 1'b0, 2'b10, 2'b00, 3};
        vt[4] = '{2'b01, 4'd15, 4'd0, 1'b0, 2'b01, 2'b01, 1};
        vt[5] = '{2'b10, 4'd0, 4'd0,  1'b0, 2'b10, 2'b00, 3};
        vt[6] = '{2'b01, 4'd12, 4'd0, 1'b0, 2'b01, 2'b01, 1};
        vt[7] = '{2'b01, 4'd11, 4'd0, 1'b0, 2'b01, 2'b00, 3};

        #3;
        chk("rst_load", load, 0); chk("rst_I", I, 0); chk("rst_ack", ack, 0);
        chk("rst_err", err, 0); chk("rst_busy", busy, 0); chk("rst_tc", tc, 0);
        do_reset();

        foreach (vt[k]) begin
            @(negedge clk);
            p0 = vt[k].a; p1 = vt[k].b; stuck = vt[k].st; req = vt[k].rq;
            wait_ack(ga, ge, lat, nld, li);
            req = 2'b00; stuck = 1'b0;
            chk($sformatf("vec%0d_ack", k), ga, vt[k].xack);
            chk($sformatf("vec%0d_err", k), ge, vt[k].xerr);
            chk($sformatf("vec%0d_lat", k), lat, vt[k].lat);
            chk($sformatf("vec%0d_loads", k), nld, vt[k].lat == 3 ? 1 : 0);
            if (vt[k].lat == 3) chk($sformatf("vec%0d_I", k), li, vt[k].rq[0] ? vt[k].a : vt[k].b);
        end

        // tie: requester 0 first after reset, then alternation
        do_reset();
        @(negedge clk);
        p0 = 4'd3; p1 = 4'd9; req = 2'b11;
        wait_ack(ga, ge, lat, nld, li);
        chk("tie1_ack", ga, 2'b01); chk("tie1_err", ge, 2'b00); chk("tie1_I", li, 3);
        req = 2'b10;
        @(negedge clk);
        req = 2'b11;
        wait_ack(ga, ge, lat, nld, li);
        chk("tie2_ack", ga, 2'b10); chk("tie2_err", ge, 2'b00); chk("tie2_I", li, 9);
        req = 2'b01;
        @(negedge clk);
        req = 2'b11;
        wait_ack(ga, ge, lat, nld, li);
        chk("tie3_ack", ga, 2'b01); chk("tie3_I", li, 3);
        req = 2'b00;

        // reset during ISSUE aborts the request; held req restarts cleanly
        do_reset();
        @(negedge clk);
        p0 = 4'd7; req = 2'b01;
        @(negedge clk);
        chk("abort_load_pre", load, 1);
        #1 rst = 1'b0;
        #1;
        chk("abort_load", load, 0); chk("abort_I", I, 0); chk("abort_ack", ack, 0);
        chk("abort_err", err, 0); chk("abort_busy", busy, 0);
        @(negedge clk);
        chk("abort_ack_hold", ack, 0);
        rst = 1'b1;
        wait_ack(ga, ge, lat, nld, li);
        chk("restart_ack", ga, 2'b01); chk("restart_err", ge, 2'b00);
        chk("restart_lat", lat, 3); chk("restart_I", li, 7);
        req = 2'b00;

        // free-running counter through the terminal count
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            chk("tc", tc, qc == 4'd11);
        end

        begin
            int         free_at, load_at, ver_at, ack_at;
            logic       m_last, m_gnt, m_bad, g, dropped;
            logic [3:0] m_pre, m_I;
            logic [1:0] xa, xe;
            do_reset();
            free_at = 0; load_at = -1; ver_at = -1; ack_at = -1;
            m_last = 1'b1; m_gnt = 1'b0; m_bad = 1'b0; m_pre = '0; m_I = '0;
            for (int c = 0; c < 600; c++) begin
                @(negedge clk);
                if (c == ver_at) m_bad = qc != m_pre;
                xa = (c == ack_at) ? 2'b01 << m_gnt : 2'b00;
                xe = (c == ack_at && m_bad) ? xa : 2'b00;
                if (c == load_at) m_I = m_pre;
                chk("rnd_load", load, c == load_at);
                chk("rnd_I", I, m_I);
                chk("rnd_ack", ack, xa);
                chk("rnd_err", err, xe);
                chk("rnd_busy", busy, c < free_at);
                dropped = 1'b0;
                if (c == ack_at) begin req[m_gnt] = 1'b0; dropped = 1'b1; end
                for (int r = 0; r < 2; r++)
                    if (!req[r] && !(dropped && m_gnt == r[0]) && $urandom_range(0, 2) == 0) begin
                        li = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(12, 15)) : 4'($urandom_range(0, 11));
                        if (r == 0) p0 = li; else p1 = li;
                        req[r] = 1'b1;
                    end
                stuck = $urandom_range(0, 9) == 0;
                if (c >= free_at && req != 2'b00) begin
                    g = (req == 2'b11) ? ~m_last : req[1];
                    m_last = g; m_gnt = g;
                    m_pre = g ? p1 : p0;
                    if (m_pre < 4'd12) begin
                        load_at = c + 1; ver_at = c + 2; ack_at = c + 3; free_at = c + 4;
                    end else begin
                        load_at = -1; ver_at = -1; ack_at = c + 1; free_at = c + 2; m_bad = 1'b1;
                    end
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mod12_load_scheduler.md
# mod12_load_scheduler

Controller that shares the load port of the synchronous mod-12 counter between two requesters. Each requester presents a preset and a request; the block arbitrates round-robin, range-checks the preset, drives a one-cycle `load` pulse with the preset on `I`, confirms the counter took the value, and acknowledges. It sits between the requesting logic and the counter's `load`/`I`/`q` ports; the counter itself is instantiated outside this block.

## Interface
- `W`, 4: counter/preset width.
- `MOD`, 12: counter modulus; valid presets are 0..MOD-1.

- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  reset, asynchronous, active-low.
- `req`  in  2  per-requester load request; held high until ack.
- `preset0`  in  W  requester 0 preset; stable while `req[0]` high.
- `preset1`  in  W  requester 1 preset; stable while `req[1]` high.
- `q`  in  W  counter output, fed back for load verification.
- `load`  out  1  counter load strobe, registered.
- `I`  out  W  counter parallel-load value, registered.
- `ack`  out  2  one-hot, one-cycle completion pulse per requester.
- `err`  out  2  valid only with matching `ack` bit; 1 = rejected or load not confirmed.
- `busy`  out  1  high in every state except IDLE.
- `tc`  out  1  combinational, `q == MOD-1`.

## Operation
- States: IDLE, ISSUE, VERIFY, DONE.
- IDLE: if any `req` bit set, grant one (round-robin below), capture its preset into `pre_r` and the grant index into `gnt_r`.
  - preset < MOD -> ISSUE.
  - preset >= MOD -> DONE with `err_r=1`; no load issued.
- ISSUE: `load=1`, `I=pre_r` for exactly one cycle -> VERIFY.
- VERIFY: compare `q` with `pre_r`; `err_r = (q != pre_r)` -> DONE.
- DONE: `ack[gnt_r]=1`, `err[gnt_r]=err_r`, all other bits 0 -> IDLE.
- Round-robin: `last` pointer records the last granted requester. With both requesting, grant `~last`; with one requesting, grant it. Pointer updates on every grant, including rejects. After reset, requester 0 wins a tie.
- Requester rule: drop `req` on the clock edge ending its `ack` cycle, so IDLE never re-grants a completed request. A request arriving while `busy` waits; it is not lost.
- `I` holds its last issued value outside ISSUE. `load` is 0 outside ISSUE.
- Width: preset comparison against MOD is unsigned in W bits.

## Timing
- Reset (asynchronous, any state): state=IDLE, `last`=1 (requester 0 favoured), `load`=0, `I`=0, `ack`=0, `err`=0, `busy`=0, `pre_r`=0, `gnt_r`=0. `tc` follows `q`.
- Valid load, with `req` sampled high in IDLE at cycle t:
  - cycle t+1: `load`=1, `I`=preset.
  - cycle t+2: `q`=preset; VERIFY.
  - cycle t+3: ack pulse.
  - Total: 3 cycles request-to-ack; next grant possible at t+4.
- Invalid preset: ack+err in cycle t+1; `load` never asserts.
- Reset mid-operation: any pending ack is dropped. Requesters still holding `req` are re-arbitrated from IDLE after reset release.
- Counter wrap: a preset of 11 is loaded and verified normally. VERIFY samples `q` exactly one cycle after the load edge, before the counter advances.

## Structure
- Shared package: state encoding constants (IDLE/ISSUE/VERIFY/DONE), `MOD` and `W` defaults.
- One natural sub-module: `rr_arbiter2`. Two-input round-robin grant with a `last` pointer and an update enable. Everything else stays in the top FSM.

## Test plan
- Reset, then `req=01`, `preset0=6`:
  - `load`=1 with `I=6` one cycle after the request.
  - `q`=6 on the next cycle.
  - `ack=01`, `err=00` three cycles after the request.
- `req=11`, `preset0=3`, `preset1=9`, held:
  - requester 0 served first (ack 01, q=3).
  - then requester 1 (ack 10, q=9).
  - then requester 0 again if still requesting.
- `req=10`, `preset1=13`: `ack=10`, `err=10` one cycle after the request; `load` stays 0 throughout.
- Counter model forced to ignore `load`, `preset0=5`, `q`≠5 at VERIFY: `ack=01`, `err=01`.
- Drive `rst`=0 during ISSUE, then release:
  - all outputs 0 immediately.
  - no ack for the aborted request.
  - with `req=01` still held, the full sequence restarts.
- Free-running counter through 11: `tc`=1 exactly while `q=11`. A preset of 11 loads and verifies with `err`=0.
